svram_sdram_sched: RTL



---
 rtl/svram_sdram_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/svram_sdram_sched.sv
// Slow-VRAM to SDRAM scheduler: 1-entry dword read cache, 1-deep write buffer; hits answer next CLK,
// misses/writes take one SDRAM request/ack/rdy round trip; a full write buffer drops new writes (WR_OVF).
module svram_sdram_sched #(
    parameter int            AW      = 24,
    parameter logic [AW-1:0] BASE    = 'h0E0000,
    parameter int            MAX_LAT = 6
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CLK_EN_24M_P,
    input  logic [14:0]   SVRAM_ADDR,
    input  logic [15:0]   SVRAM_DATA_OUT,
    input  logic [1:0]    VRAM_CYCLE,
    input  logic          BOE,
    input  logic          BWE,
    output logic [31:0]   SVRAM_DATA_IN,
    output logic          SDRAM_REQ,
    output logic          SDRAM_WE,
    output logic [AW-1:0] SDRAM_ADDR,
    output logic [15:0]   SDRAM_DIN,
    output logic [1:0]    SDRAM_BE,
    input  logic          SDRAM_ACK,
    input  logic          SDRAM_RDY,
    input  logic [31:0]   SDRAM_DOUT,
    output logic          BUSY,
    output logic          LATE,
    output logic          WR_OVF
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;

    localparam logic [3:0] MAX_LAT_C = 4'(MAX_LAT);

    state_t      state;
    logic [14:0] prev_addr;
    logic        prev_bwe;
    logic        cache_vld;
    logic [13:0] cache_tag;
    logic [31:0] cache_dat;
    logic        rd_pend;
    logic [14:0] rd_addr;
    logic [14:0] fl_addr;
    logic        wb_full;
    logic [14:0] wb_addr;
    logic [15:0] wb_dat;
    logic [3:0]  lat_cnt;

    logic        rd_trig, rd_hit, wr_trig, wr_acc, wt_hit;
    logic        wb_issue, rd_done;
    logic [3:0]  lat_nxt;
    logic [31:0] rd_data;
    logic        unused_boe;

    assign unused_boe = BOE;
    assign SDRAM_BE   = 2'b11;
    assign BUSY       = (state != IDLE);

    function automatic logic [31:0] map_word(input logic [31:0] d, input logic odd);
        return odd ? {d[31:16], d[31:16]} : d;
    endfunction

    always_comb begin
        rd_trig  = CLK_EN_24M_P && (VRAM_CYCLE != 2'b11) && (SVRAM_ADDR != prev_addr);
        rd_hit   = cache_vld && (cache_tag == SVRAM_ADDR[14:1]);
        wr_trig  = CLK_EN_24M_P && !BWE && prev_bwe;
        // The slot frees as soon as its contents move into the request registers.
        wb_issue = (state == IDLE) && wb_full;
        wr_acc   = wr_trig && (!wb_full || wb_issue);
        rd_done  = SDRAM_RDY && ((state == RD_WAIT) || ((state == RD_REQ) && SDRAM_ACK));
        wt_hit   = cache_vld && (cache_tag == SVRAM_ADDR[14:1]) && !rd_done;
        lat_nxt  = (lat_cnt == 4'd15) ? lat_cnt : lat_cnt + 4'd1;
        // Returned dword absorbs any write to the same dword that landed while the read was in flight.
        rd_data  = SDRAM_DOUT;
        if (wb_full && (wb_addr[14:1] == fl_addr[14:1])) begin
            if (wb_addr[0]) rd_data[31:16] = wb_dat;
            else            rd_data[15:0]  = wb_dat;
        end
        if (wr_acc && (SVRAM_ADDR[14:1] == fl_addr[14:1])) begin
            if (SVRAM_ADDR[0]) rd_data[31:16] = SVRAM_DATA_OUT;
            else               rd_data[15:0]  = SVRAM_DATA_OUT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            prev_addr     <= 15'h7FFF;
            prev_bwe      <= 1'b1;
            cache_vld     <= 1'b0;
            cache_tag     <= '0;
            cache_dat     <= '0;
            rd_pend       <= 1'b0;
            rd_addr       <= '0;
            fl_addr       <= '0;
            wb_full       <= 1'b0;
            wb_addr       <= '0;
            wb_dat        <= '0;
            lat_cnt       <= '0;
            SVRAM_DATA_IN <= '0;
            SDRAM_REQ     <= 1'b0;
            SDRAM_WE      <= 1'b0;
            SDRAM_ADDR    <= '0;
            SDRAM_DIN     <= '0;
            LATE          <= 1'b0;
            WR_OVF        <= 1'b0;
        end else begin
            if (CLK_EN_24M_P) begin
                prev_addr <= SVRAM_ADDR;
                prev_bwe  <= BWE;
                if (state != IDLE) begin
                    lat_cnt <= lat_nxt;
                    if (lat_nxt >= MAX_LAT_C) LATE <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (wb_full) begin
                        state      <= WR_REQ;
                        SDRAM_REQ  <= 1'b1;
                        SDRAM_WE   <= 1'b1;
                        SDRAM_ADDR <= BASE | AW'({wb_addr, 1'b0});
                        SDRAM_DIN  <= wb_dat;
                        wb_full    <= 1'b0;
                        lat_cnt    <= '0;
                    end else if (rd_pend) begin
                        state      <= RD_REQ;
                        SDRAM_REQ  <= 1'b1;
                        SDRAM_WE   <= 1'b0;
                        SDRAM_ADDR <= BASE | AW'({rd_addr[14:1], 2'b00});
                        fl_addr    <= rd_addr;
                        rd_pend    <= 1'b0;
                        lat_cnt    <= '0;
                    end
                end
                WR_REQ: if (SDRAM_ACK) begin
                    SDRAM_REQ <= 1'b0;
                    state     <= SDRAM_RDY ? IDLE : WR_WAIT;
                end
                WR_WAIT: if (SDRAM_RDY) state <= IDLE;
                RD_REQ: if (SDRAM_ACK) begin
                    SDRAM_REQ <= 1'b0;
                    state     <= SDRAM_RDY ? IDLE : RD_WAIT;
                end
                RD_WAIT: if (SDRAM_RDY) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (rd_done) begin
                cache_vld     <= 1'b1;
                cache_tag     <= fl_addr[14:1];
                cache_dat     <= rd_data;
                SVRAM_DATA_IN <= map_word(rd_data, fl_addr[0]);
            end

            if (rd_trig) begin
                if (rd_hit) begin
                    SVRAM_DATA_IN <= map_word(cache_dat, SVRAM_ADDR[0]);
                end else begin
                    rd_pend <= 1'b1;
                    rd_addr <= SVRAM_ADDR;
                end
            end

            if (wr_trig) begin
                if (wr_acc) begin
                    wb_full <= 1'b1;
                    wb_addr <= SVRAM_ADDR;
                    wb_dat  <= SVRAM_DATA_OUT;
                    if (wt_hit) begin
                        if (SVRAM_ADDR[0]) cache_dat[31:16] <= SVRAM_DATA_OUT;
                        else               cache_dat[15:0]  <= SVRAM_DATA_OUT;
                    end
                end else begin
                    WR_OVF <= 1'b1;
                end
            end
        end
    end

endmodule
